// File: rtl/disk_bus_arbiter.sv
// disk_bus_arbiter: round-robin two-master arbiter for the sector-buffer disk bus with a hung-command timeout
module disk_bus_arbiter #(
    parameter int TIMEOUT = 1048576,
    parameter int TW      = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,
    output logic        busy,
    output logic        gnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;
    state_t          r_state;
    logic            r_gnt;
    logic            r_last;
    logic [TW-1:0]   r_tcnt;
    logic            w_busy;
    logic            w_gstb;
    logic            w_tout;
    assign w_busy = r_state == BUSY;
    assign w_gstb = r_gnt ? m1_stb : m0_stb;
    assign w_tout = w_busy && !s_ack && r_tcnt == TW'(TIMEOUT - 1);
    // bus mux toward the disk and ack/err/data steering back to the granted master
    always_comb begin
        s_stb    = w_busy;
        busy     = w_busy;
        gnt      = r_gnt;
        s_we     = w_busy && (r_gnt ? m1_we : m0_we);
        s_addr   = w_busy ? (r_gnt ? m1_addr : m0_addr) : '0;
        s_dat_o  = w_busy ? (r_gnt ? m1_dat_i : m0_dat_i) : '0;
        m0_ack   = w_busy && !r_gnt && s_ack;
        m1_ack   = w_busy && r_gnt && s_ack;
        m0_err   = w_tout && !r_gnt;
        m1_err   = w_tout && r_gnt;
        m0_dat_o = (w_busy && !r_gnt) ? s_dat_i : '0;
        m1_dat_o = (w_busy && r_gnt) ? s_dat_i : '0;
    end
    // arbitration in IDLE, grant held through BUSY until ack/timeout/abort, one dead GAP cycle after
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (m0_stb || m1_stb) begin
                    r_gnt   <= (m0_stb && m1_stb) ? ~r_last : m1_stb;
                    r_state <= BUSY;
                    r_tcnt  <= '0;
                end
                BUSY: if (s_ack || w_tout || !w_gstb) begin
                    r_last  <= r_gnt;
                    r_state <= GAP;
                end else begin
                    r_tcnt  <= r_tcnt + TW'(1);
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disk_bus_arbiter.sv
// tb_disk_bus_arbiter: scoreboard bench for disk_bus_arbiter
module tb_disk_bus_arbiter;
    localparam int TO = 640;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_stb = 1'b0, m0_we = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_dat_i = '0, m1_addr = '0, m1_dat_i = '0;
    logic [31:0] m0_dat_o, m1_dat_o, s_addr, s_dat_o, s_dat_i;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_stb, s_we, s_ack, busy, gnt;
    logic        auto_ack = 1'b0, man_ack = 1'b0;
    logic        pend0 = 1'b0, pend1 = 1'b0;
    int          total = 0, bad = 0;
    typedef struct packed {logic m; logic err; logic [31:0] dat;} exp_t;
    exp_t        sb[$];
    exp_t        mon_x;
    logic        mon_a, mon_e;
    logic [31:0] mon_d;
    always #5 clk = ~clk;
    assign s_dat_i = {s_addr[15:0], ~s_addr[15:0]};
    assign s_ack   = auto_ack ? s_stb : man_ack;
    disk_bus_arbiter #(.TIMEOUT(TO), .TW(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack(s_ack), .busy(busy), .gnt(gnt)
    );
    function automatic logic [31:0] disk_dat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    always @(negedge clk) begin
        #2;
        if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
            total++; bad++;
            $display("FAIL both_ack m0_ack=%b m1_ack=%b required not both", m0_ack, m1_ack);
        end
        for (int m = 0; m < 2; m++) begin
            mon_a = (m == 0) ? m0_ack : m1_ack;
            mon_e = (m == 0) ? m0_err : m1_err;
            mon_d = (m == 0) ? m0_dat_o : m1_dat_o;
            if (mon_a === 1'b1 || mon_e === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected m%0d ack=%b err=%b required nothing", m, mon_a, mon_e);
                end else begin
                    mon_x = sb.pop_front();
                    if (mon_x.m !== (m == 1) || mon_x.err !== mon_e || (!mon_e && mon_x.dat !== mon_d)) begin
                        bad++;
                        $display("FAIL sb_order got m%0d err=%b dat=%h required m%0d err=%b dat=%h",
                                 m, mon_e, mon_d, mon_x.m, mon_x.err, mon_x.dat);
                    end
                end
            end
        end
    end
    task automatic run(input int budget, output int t0, output int t1);
        int c = 0;
        t0 = -1; t1 = -1;
        while ((pend0 || pend1) && c < budget) begin
            @(negedge clk);
            m0_stb = pend0; m1_stb = pend1;
            #1;
            if (m0_ack || m0_err) begin pend0 = 1'b0; t0 = c; end
            if (m1_ack || m1_err) begin pend1 = 1'b0; t1 = c; end
            c++;
        end
        total++;
        if (pend0 || pend1) begin
            bad++;
            $display("FAIL run_budget pending=%b%b required 00 after %0d cycles", pend1, pend0, budget);
        end
        @(negedge clk);
        m0_stb = 1'b0; m1_stb = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    endtask
    task automatic test_reset();
        @(negedge clk); @(negedge clk); #1;
        total++;
        if ({s_stb, busy, gnt, m0_ack, m0_err, m1_ack, m1_err, s_we} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctl got=%b required=00000000", {s_stb, busy, gnt, m0_ack, m0_err, m1_ack, m1_err, s_we});
        end
        total++;
        if (s_addr !== 32'h0 || s_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_bus addr=%h dat=%h required 0", s_addr, s_dat_o);
        end
        rst_n = 1'b1;
    endtask
    task automatic test_single_read();
        auto_ack = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        @(negedge clk);
        m0_stb = 1'b1;
        sb.push_back('{m: 1'b0, err: 1'b0, dat: disk_dat(32'h10)});
        #1;
        total++;
        if (s_stb !== 1'b0) begin bad++; $display("FAIL rd_c0_stb got=%b required=0", s_stb); end
        @(negedge clk); #1;
        total++;
        if (s_stb !== 1'b1 || m0_ack !== 1'b1 || gnt !== 1'b0 || s_addr !== 32'h10) begin
            bad++;
            $display("FAIL rd_c1 stb=%b ack=%b gnt=%b addr=%h required 1 1 0 00000010", s_stb, m0_ack, gnt, s_addr);
        end
        total++;
        if (m0_dat_o !== disk_dat(32'h10) || m1_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL rd_dat m0=%h m1=%h required %h 0", m0_dat_o, m1_dat_o, disk_dat(32'h10));
        end
        @(negedge clk);
        m0_stb = 1'b0;
        #1;
        total++;
        if (s_stb !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rd_gap stb=%b busy=%b required 0 0", s_stb, busy); end
        @(negedge clk);
    endtask
    task automatic test_round_robin();
        int t0, t1;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        auto_ack = 1'b1;
        for (int r = 0; r < 2; r++) begin
            m0_addr = 32'h100 + r; m1_addr = 32'h200 + r;
            sb.push_back('{m: 1'b0, err: 1'b0, dat: disk_dat(m0_addr)});
            sb.push_back('{m: 1'b1, err: 1'b0, dat: disk_dat(m1_addr)});
            pend0 = 1'b1; pend1 = 1'b1;
            run(20, t0, t1);
            total++;
            if (t0 !== 1 || t1 !== 4) begin
                bad++;
                $display("FAIL rr_timing round=%0d ack0=%0d ack1=%0d required 1 4", r, t0, t1);
            end
        end
    endtask
    task automatic test_timeout();
        int err_at = 0, n_err = 0, acks = 0;
        auto_ack = 1'b0; man_ack = 1'b0;
        m1_we = 1'b1; m1_addr = 32'h300; m1_dat_i = 32'hDEADBEEF;
        sb.push_back('{m: 1'b1, err: 1'b1, dat: 32'h0});
        @(negedge clk);
        m1_stb = 1'b1;
        for (int i = 1; i <= TO + 4 && err_at == 0; i++) begin
            @(negedge clk); #1;
            if (i == 1) begin
                total++;
                if (s_we !== 1'b1 || s_addr !== 32'h300 || s_dat_o !== 32'hDEADBEEF || gnt !== 1'b1) begin
                    bad++;
                    $display("FAIL to_wr we=%b addr=%h dat=%h gnt=%b required 1 300 deadbeef 1", s_we, s_addr, s_dat_o, gnt);
                end
            end
            if (m1_err) begin n_err++; err_at = i; end
            if (m1_ack) acks++;
        end
        total++;
        if (err_at !== TO || n_err !== 1 || acks !== 0) begin
            bad++;
            $display("FAIL to_cycle err_at=%0d errs=%0d acks=%0d required %0d 1 0", err_at, n_err, acks, TO);
        end
        @(negedge clk);
        m1_stb = 1'b0; m1_we = 1'b0;
        #1;
        total++;
        if (s_stb !== 1'b0 || m1_err !== 1'b0) begin bad++; $display("FAIL to_gap stb=%b err=%b required 0 0", s_stb, m1_err); end
        @(negedge clk);
    endtask
    task automatic test_long_sector();
        int early = 0;
        auto_ack = 1'b0; man_ack = 1'b0;
        m0_addr = 32'h400; m1_addr = 32'h500;
        sb.push_back('{m: 1'b0, err: 1'b0, dat: disk_dat(32'h400)});
        sb.push_back('{m: 1'b1, err: 1'b0, dat: disk_dat(32'h500)});
        @(negedge clk);
        m0_stb = 1'b1;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i == 5) m1_stb = 1'b1;
            if (i == 600) man_ack = 1'b1;
            #1;
            if (i < 600 && (m0_ack || m1_ack || busy !== 1'b1 || gnt !== 1'b0)) early++;
        end
        total++;
        if (early !== 0 || m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            bad++;
            $display("FAIL ls_hold early=%0d m0_ack=%b m1_ack=%b required 0 1 0", early, m0_ack, m1_ack);
        end
        @(negedge clk);
        man_ack = 1'b0; m0_stb = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ls_gap busy=%b required=0", busy); end
        @(negedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ls_idle busy=%b required=0", busy); end
        @(negedge clk);
        auto_ack = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1 || gnt !== 1'b1 || m1_ack !== 1'b1) begin
            bad++;
            $display("FAIL ls_m1 busy=%b gnt=%b ack=%b required 1 1 1", busy, gnt, m1_ack);
        end
        @(negedge clk);
        m1_stb = 1'b0;
    endtask
    task automatic test_abort();
        int t0, t1;
        auto_ack = 1'b0; man_ack = 1'b0; m0_addr = 32'h600;
        @(negedge clk); m0_stb = 1'b1;
        @(negedge clk); @(negedge clk);
        @(negedge clk);
        m0_stb = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1 || m0_ack !== 1'b0 || m0_err !== 1'b0) begin
            bad++;
            $display("FAIL ab_c3 busy=%b ack=%b err=%b required 1 0 0", busy, m0_ack, m0_err);
        end
        @(negedge clk); #1;
        total++;
        if (s_stb !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ab_gap stb=%b busy=%b required 0 0", s_stb, busy); end
        auto_ack = 1'b1; m0_addr = 32'h700; m1_addr = 32'h800;
        sb.push_back('{m: 1'b1, err: 1'b0, dat: disk_dat(32'h800)});
        sb.push_back('{m: 1'b0, err: 1'b0, dat: disk_dat(32'h700)});
        pend0 = 1'b1; pend1 = 1'b1;
        run(20, t0, t1);
        total++;
        if (t1 !== 1 || t0 !== 4) begin bad++; $display("FAIL ab_tie ack1=%0d ack0=%0d required 1 4", t1, t0); end
    endtask
    task automatic test_reset_mid_busy();
        int t0, t1;
        auto_ack = 1'b0; man_ack = 1'b0; m0_addr = 32'h900;
        @(negedge clk); m0_stb = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0; m0_stb = 1'b0;
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rm_pre busy=%b required=1", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || s_stb !== 1'b0 || gnt !== 1'b0 || s_addr !== 32'h0) begin
            bad++;
            $display("FAIL rm_post busy=%b stb=%b gnt=%b addr=%h required 0 0 0 0", busy, s_stb, gnt, s_addr);
        end
        auto_ack = 1'b1; m0_addr = 32'hA00; m1_addr = 32'hB00;
        sb.push_back('{m: 1'b0, err: 1'b0, dat: disk_dat(32'hA00)});
        sb.push_back('{m: 1'b1, err: 1'b0, dat: disk_dat(32'hB00)});
        pend0 = 1'b1; pend1 = 1'b1;
        run(20, t0, t1);
        total++;
        if (t0 !== 1 || t1 !== 4) begin bad++; $display("FAIL rm_tie ack0=%0d ack1=%0d required 1 4", t0, t1); end
    endtask
    task automatic test_stray_ack();
        int hits = 0;
        auto_ack = 1'b0; man_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (m0_ack || m1_ack || s_stb) hits++;
        end
        man_ack = 1'b0;
        total++;
        if (hits !== 0) begin bad++; $display("FAIL stray_ack hits=%0d required=0", hits); end
    endtask
    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_long_sector();
        test_abort();
        test_reset_mid_busy();
        test_stray_ack();
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
